// File: rtl/round_sequencer.sv
// Crossy Robbers game sequencer: menu, countdown, timed play, end-of-round.
// Owns frame/second timers, loot scores, winner and entity control pulses.
module round_sequencer #(
  parameter int FRAMES_PER_SEC = 60,
  parameter int COUNTDOWN_SEC  = 3,
  parameter int ROUND_SEC      = 90,
  parameter int END_HOLD_SEC   = 5,
  parameter int SCORE_W        = 8
) (
  input  logic               Clk,
  input  logic               Reset,
  input  logic               frame_tick,
  input  logic               start,
  input  logic               p1_hit,
  input  logic               p2_hit,
  input  logic               p1_deposit,
  input  logic               p2_deposit,
  output logic [1:0]         state,
  output logic [1:0]         countdown,
  output logic [6:0]         time_left,
  output logic [SCORE_W-1:0] p1_score,
  output logic [SCORE_W-1:0] p2_score,
  output logic [1:0]         winner,
  output logic               run,
  output logic               respawn_p1,
  output logic               respawn_p2,
  output logic               round_init
);

  typedef enum logic [1:0] {
    S_MENU = 2'b00,
    S_CD   = 2'b01,
    S_PLAY = 2'b10,
    S_END  = 2'b11
  } state_e;

  localparam int FW = $clog2(FRAMES_PER_SEC + 1);
  localparam int HW = $clog2(END_HOLD_SEC + 1);
  localparam logic [SCORE_W-1:0] SMAX = '1;

  state_e             state_q, state_d;
  logic [1:0]         countdown_q, countdown_d;
  logic [6:0]         time_left_q, time_left_d;
  logic [SCORE_W-1:0] p1_score_q, p1_score_d;
  logic [SCORE_W-1:0] p2_score_q, p2_score_d;
  logic [1:0]         winner_q, winner_d;
  logic               run_q, run_d;
  logic               resp1_q, resp1_d;
  logic               resp2_q, resp2_d;
  logic               init_q, init_d;
  logic [FW-1:0]      frame_cnt_q, frame_cnt_d;
  logic [HW-1:0]      hold_cnt_q, hold_cnt_d;
  logic               start_q;
  logic               start_rise;
  logic               sec_tick;

  function automatic logic [1:0] pick_winner(
    input logic [SCORE_W-1:0] a,
    input logic [SCORE_W-1:0] b
  );
    if (a > b)      return 2'b01;
    else if (b > a) return 2'b10;
    else            return 2'b11;
  endfunction

  assign start_rise = start & ~start_q;
  assign sec_tick   = frame_tick &&
                      (frame_cnt_q == FW'(FRAMES_PER_SEC - 1));

  always_comb begin
    state_d     = state_q;
    countdown_d = countdown_q;
    time_left_d = time_left_q;
    p1_score_d  = p1_score_q;
    p2_score_d  = p2_score_q;
    winner_d    = winner_q;
    hold_cnt_d  = hold_cnt_q;
    resp1_d     = 1'b0;
    resp2_d     = 1'b0;
    init_d      = 1'b0;
    frame_cnt_d = frame_cnt_q;
    if (frame_tick)
      frame_cnt_d = sec_tick ? '0 : frame_cnt_q + FW'(1);

    unique case (state_q)
      S_MENU: begin
        if (start_rise) begin
          state_d     = S_CD;
          p1_score_d  = '0;
          p2_score_d  = '0;
          winner_d    = 2'b00;
          countdown_d = 2'(COUNTDOWN_SEC);
          time_left_d = 7'(ROUND_SEC);
          init_d      = 1'b1;
        end
      end
      S_CD: begin
        if (sec_tick) begin
          countdown_d = countdown_q - 2'd1;
          if (countdown_q == 2'd1) state_d = S_PLAY;
        end
      end
      S_PLAY: begin
        // a hit in the same cycle as a deposit forfeits the deposit
        if (p1_hit) resp1_d = 1'b1;
        else if (p1_deposit && p1_score_q != SMAX)
          p1_score_d = p1_score_q + 1'b1;
        if (p2_hit) resp2_d = 1'b1;
        else if (p2_deposit && p2_score_q != SMAX)
          p2_score_d = p2_score_q + 1'b1;
        if (sec_tick) begin
          time_left_d = time_left_q - 7'd1;
          if (time_left_q == 7'd1) begin
            state_d    = S_END;
            hold_cnt_d = '0;
            winner_d   = pick_winner(p1_score_d, p2_score_d);
          end
        end
      end
      S_END: begin
        if (start_rise) begin
          state_d = S_MENU;
        end else if (sec_tick) begin
          hold_cnt_d = hold_cnt_q + HW'(1);
          if (hold_cnt_q == HW'(END_HOLD_SEC - 1)) state_d = S_MENU;
        end
      end
      default: state_d = S_MENU;
    endcase

    if (state_d != state_q) frame_cnt_d = '0;
    run_d = (state_d == S_PLAY);
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q     <= S_MENU;
      countdown_q <= '0;
      time_left_q <= 7'(ROUND_SEC);
      p1_score_q  <= '0;
      p2_score_q  <= '0;
      winner_q    <= 2'b00;
      run_q       <= 1'b0;
      resp1_q     <= 1'b0;
      resp2_q     <= 1'b0;
      init_q      <= 1'b0;
      frame_cnt_q <= '0;
      hold_cnt_q  <= '0;
      start_q     <= 1'b1;
    end else begin
      state_q     <= state_d;
      countdown_q <= countdown_d;
      time_left_q <= time_left_d;
      p1_score_q  <= p1_score_d;
      p2_score_q  <= p2_score_d;
      winner_q    <= winner_d;
      run_q       <= run_d;
      resp1_q     <= resp1_d;
      resp2_q     <= resp2_d;
      init_q      <= init_d;
      frame_cnt_q <= frame_cnt_d;
      hold_cnt_q  <= hold_cnt_d;
      start_q     <= start;
    end
  end

  assign state      = state_q;
  assign countdown  = countdown_q;
  assign time_left  = time_left_q;
  assign p1_score   = p1_score_q;
  assign p2_score   = p2_score_q;
  assign winner     = winner_q;
  assign run        = run_q;
  assign respawn_p1 = resp1_q;
  assign respawn_p2 = resp2_q;
  assign round_init = init_q;

endmodule

// File: tb/tb_round_sequencer.sv
// Scoreboard bench for round_sequencer with short timers and 2-bit scores.
// Expectations are queued before each clock and compared after it.
module tb_round_sequencer;

  localparam int FPS = 2;
  localparam int CDS = 3;
  localparam int RS  = 2;
  localparam int EHS = 2;
  localparam int SW  = 2;

  localparam int S_ST = 0, S_CD = 1, S_TL = 2, S_P1 = 3, S_P2 = 4;
  localparam int S_WN = 5, S_RN = 6, S_R1 = 7, S_R2 = 8, S_RI = 9;

  logic          Clk, Reset, frame_tick, start;
  logic          p1_hit, p2_hit, p1_deposit, p2_deposit;
  logic [1:0]    state, countdown, winner;
  logic [6:0]    time_left;
  logic [SW-1:0] p1_score, p2_score;
  logic          run, respawn_p1, respawn_p2, round_init;

  round_sequencer #(
    .FRAMES_PER_SEC(FPS),
    .COUNTDOWN_SEC (CDS),
    .ROUND_SEC     (RS),
    .END_HOLD_SEC  (EHS),
    .SCORE_W       (SW)
  ) dut (
    .Clk(Clk), .Reset(Reset), .frame_tick(frame_tick), .start(start),
    .p1_hit(p1_hit), .p2_hit(p2_hit),
    .p1_deposit(p1_deposit), .p2_deposit(p2_deposit),
    .state(state), .countdown(countdown), .time_left(time_left),
    .p1_score(p1_score), .p2_score(p2_score), .winner(winner),
    .run(run), .respawn_p1(respawn_p1), .respawn_p2(respawn_p2),
    .round_init(round_init)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  typedef struct {
    string tag;
    int    sel;
    int    exp;
  } exp_t;

  exp_t sbq[$];
  int   n_chk  = 0;
  int   n_pass = 0;

  function automatic int obs(input int sel);
    case (sel)
      S_ST:    return int'(state);
      S_CD:    return int'(countdown);
      S_TL:    return int'(time_left);
      S_P1:    return int'(p1_score);
      S_P2:    return int'(p2_score);
      S_WN:    return int'(winner);
      S_RN:    return int'(run);
      S_R1:    return int'(respawn_p1);
      S_R2:    return int'(respawn_p2);
      S_RI:    return int'(round_init);
      default: return -1;
    endcase
  endfunction

  task automatic check_eq(input string tag, input int o, input int e);
    n_chk++;
    if (o !== e)
      $display("FAIL %s: got %0d expected %0d", tag, o, e);
    else
      n_pass++;
  endtask

  task automatic push(input string tag, input int sel, input int e);
    exp_t x;
    x.tag = tag;
    x.sel = sel;
    x.exp = e;
    sbq.push_back(x);
  endtask

  task automatic step();
    exp_t x;
    @(posedge Clk);
    #1;
    while (sbq.size() != 0) begin
      x = sbq.pop_front();
      check_eq(x.tag, obs(x.sel), x.exp);
    end
  endtask

  task automatic tick();
    frame_tick = 1'b1;
    step();
    frame_tick = 1'b0;
  endtask

  task automatic go_play();
    start = 1'b0;
    step();
    start = 1'b1;
    push("go_init", S_RI, 1);
    push("go_p1clr", S_P1, 0);
    push("go_p2clr", S_P2, 0);
    push("go_wclr", S_WN, 0);
    step();
    start = 1'b0;
    repeat (FPS * CDS - 1) tick();
    push("go_play", S_ST, 2);
    push("go_run", S_RN, 1);
    tick();
  endtask

  task automatic dep(input bit a, input bit b, input int e1, input int e2);
    p1_deposit = a;
    p2_deposit = b;
    push("dep_p1", S_P1, e1);
    push("dep_p2", S_P2, e2);
    step();
    p1_deposit = 1'b0;
    p2_deposit = 1'b0;
  endtask

  initial begin
    Reset = 1'b1; start = 1'b1; frame_tick = 1'b0;
    p1_hit = 1'b0; p2_hit = 1'b0; p1_deposit = 1'b0; p2_deposit = 1'b0;
    push("rst_state", S_ST, 0);
    push("rst_cd", S_CD, 0);
    push("rst_tl", S_TL, RS);
    push("rst_p1", S_P1, 0);
    push("rst_p2", S_P2, 0);
    push("rst_win", S_WN, 0);
    push("rst_run", S_RN, 0);
    push("rst_init", S_RI, 0);
    push("rst_r1", S_R1, 0);
    push("rst_r2", S_R2, 0);
    step();
    Reset = 1'b0;
    repeat (10) begin
      push("held_state", S_ST, 0);
      push("held_init", S_RI, 0);
      step();
    end

    start = 1'b0;
    step();
    start = 1'b1;
    push("cd_state", S_ST, 1);
    push("cd_val", S_CD, CDS);
    push("cd_tl", S_TL, RS);
    push("cd_init", S_RI, 1);
    step();
    push("init_pulse", S_RI, 0);
    step();
    start = 1'b0;
    step();
    start = 1'b1;
    push("cd_ignstart", S_ST, 1);
    push("cd_ignval", S_CD, CDS);
    step();
    start = 1'b0;
    p1_hit = 1'b1; p1_deposit = 1'b1;
    push("cd_igndep", S_P1, 0);
    push("cd_ignhit", S_R1, 0);
    step();
    p1_hit = 1'b0; p1_deposit = 1'b0;
    for (int i = 1; i <= FPS * CDS; i++) begin
      push("cd_seq", S_CD, (i < 2) ? 3 : (i < 4) ? 2 : (i < 6) ? 1 : 0);
      push("cd_st", S_ST, (i < FPS * CDS) ? 1 : 2);
      push("cd_run", S_RN, (i < FPS * CDS) ? 0 : 1);
      tick();
    end

    dep(1, 0, 1, 0);
    dep(1, 0, 2, 0);
    dep(1, 1, 3, 1);
    p2_hit = 1'b1; p2_deposit = 1'b1;
    push("hitwin_p2", S_P2, 1);
    push("hitwin_r2", S_R2, 1);
    push("hitwin_r1", S_R1, 0);
    step();
    p2_hit = 1'b0; p2_deposit = 1'b0;
    push("r2_once", S_R2, 0);
    step();
    p1_hit = 1'b1;
    push("hit_r1", S_R1, 1);
    push("hit_p1", S_P1, 3);
    step();
    p1_hit = 1'b0;
    dep(1, 0, 3, 1);
    dep(1, 1, 3, 2);
    push("sat_tl", S_TL, RS);
    step();

    push("tl_t1", S_TL, 2);
    tick();
    push("tl_t2", S_TL, 1);
    push("tl_st", S_ST, 2);
    tick();
    tick();
    p2_deposit = 1'b1;
    push("end_state", S_ST, 3);
    push("end_tl", S_TL, 0);
    push("end_p2", S_P2, 3);
    push("end_win", S_WN, 3);
    push("end_run", S_RN, 0);
    tick();
    p2_deposit = 1'b0;
    p1_hit = 1'b1;
    push("end_ignhit", S_R1, 0);
    step();
    p1_hit = 1'b0;
    for (int i = 1; i <= FPS * EHS; i++) begin
      push("hold_st", S_ST, (i < FPS * EHS) ? 3 : 0);
      tick();
    end
    push("menu_p1", S_P1, 3);
    push("menu_p2", S_P2, 3);
    push("menu_win", S_WN, 3);
    step();

    go_play();
    dep(1, 1, 1, 1);
    dep(1, 0, 2, 1);
    repeat (FPS * RS - 1) tick();
    push("r2_win", S_WN, 1);
    push("r2_end", S_ST, 3);
    tick();
    start = 1'b1;
    push("end_skip", S_ST, 0);
    step();
    start = 1'b0;

    go_play();
    dep(0, 1, 0, 1);
    repeat (FPS * RS - 1) tick();
    push("r3_win", S_WN, 2);
    tick();
    repeat (FPS * EHS) tick();

    go_play();
    dep(1, 1, 1, 1);
    Reset = 1'b1;
    p1_hit = 1'b1; p2_hit = 1'b1;
    push("mid_state", S_ST, 0);
    push("mid_p1", S_P1, 0);
    push("mid_p2", S_P2, 0);
    push("mid_run", S_RN, 0);
    push("mid_r1", S_R1, 0);
    push("mid_r2", S_R2, 0);
    push("mid_tl", S_TL, RS);
    step();
    Reset = 1'b0;
    p1_hit = 1'b0; p2_hit = 1'b0;
    push("post_r1", S_R1, 0);
    push("post_state", S_ST, 0);
    step();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/round_sequencer.md
Name: round_sequencer

Overview:
- Top-level game sequencer for Crossy Robbers. Steps the game through menu, pre-round countdown, timed play and end-of-round phases.
- Keeps the per-frame/per-second timers and both players' loot scores, and issues respawn and round-init pulses to the sprite/entity logic.
- Sits between the input decoder (buttons, collision/deposit events) and the renderer/entity movers; everything advances on the vsync-derived frame_tick.

Parameters:
- FRAMES_PER_SEC, 60, frame_ticks per game second
- COUNTDOWN_SEC, 3, countdown length in seconds (1..3)
- ROUND_SEC, 90, play-phase length in seconds (1..127)
- END_HOLD_SEC, 5, seconds END is shown before auto-return to MENU (>=1)
- SCORE_W, 8, score counter width

Ports:
- Clk  in  1  system clock
- Reset  in  1  synchronous active-high reset
- frame_tick  in  1  one-cycle pulse per video frame
- start  in  1  start button, level, already debounced
- p1_hit  in  1  one-cycle pulse: player 1 struck by traffic
- p2_hit  in  1  one-cycle pulse: player 2 struck by traffic
- p1_deposit  in  1  one-cycle pulse: player 1 banked loot
- p2_deposit  in  1  one-cycle pulse: player 2 banked loot
- state  out  2  00 MENU, 01 COUNTDOWN, 10 PLAY, 11 END
- countdown  out  2  seconds remaining in COUNTDOWN, else 0
- time_left  out  7  seconds remaining in PLAY
- p1_score  out  SCORE_W  player 1 score
- p2_score  out  SCORE_W  player 2 score
- winner  out  2  00 none, 01 P1, 10 P2, 11 tie; valid in END
- run  out  1  high only in PLAY; enables entity motion
- respawn_p1  out  1  one-cycle pulse, return player 1 to spawn
- respawn_p2  out  1  one-cycle pulse, return player 2 to spawn
- round_init  out  1  one-cycle pulse, reset all entity positions

Behaviour:
- Interface: Clk is the clock. Reset is synchronous and active-high. All outputs are registered.
- Reset values:
  - state=MENU, countdown=0, time_left=ROUND_SEC
  - scores=0, winner=00, run=0, all pulses 0
  - frame counter=0, sec counter=0, start history=1, so a button held through reset does not trigger a start.
- start_rise = start & ~start_q, where start_q is start registered by one cycle.
- sec_tick:
  - Asserted when frame_tick=1 and frame_cnt==FRAMES_PER_SEC-1; frame_cnt wraps to 0 on that cycle.
  - frame_cnt is cleared on every state change, so each phase starts on a whole-second boundary.
- MENU -> COUNTDOWN on start_rise:
  - Same edge: scores<=0, winner<=00, countdown<=COUNTDOWN_SEC, time_left<=ROUND_SEC, round_init=1 for one cycle.
- COUNTDOWN:
  - Each sec_tick decrements countdown.
  - On the sec_tick where countdown==1: countdown<=0 and state<=PLAY. run rises the next cycle; latency is exactly COUNTDOWN_SEC*FRAMES_PER_SEC frame_ticks.
  - start is ignored.
- PLAY:
  - run=1. Each sec_tick decrements time_left.
  - On the sec_tick where time_left==1: time_left<=0, state<=END, winner latched from the final scores, including any score update in that same cycle.
  - pN_deposit increments pN_score, saturating at all-ones with no wrap.
  - pN_hit raises respawn_pN the next cycle, as a one-cycle pulse. Score is unchanged.
  - Hit and deposit for the same player in the same cycle: the hit wins (respawn pulse, no score).
  - The two players are independent; simultaneous events on P1 and P2 are both honoured.
- Events outside PLAY: hit/deposit inputs are ignored entirely (no score change, no respawn).
- END:
  - run=0. Scores and winner hold.
  - Returns to MENU after END_HOLD_SEC sec_ticks, or immediately on start_rise, whichever comes first.
  - Scores stay visible in MENU until the next start.
- Winner rule: p1>p2 gives 01, p2>p1 gives 10, equal gives 11.
- Reset mid-operation: returns to MENU on the next edge from any state and clears everything as listed above; pulses in flight are dropped.
- frame_tick with no sec_tick boundary and no event: no output changes except the internal frame_cnt.

Test Plan:
- Reset with start held high, then hold 10 cycles -> state stays 00, scores 0, time_left=ROUND_SEC, no round_init.
- FRAMES_PER_SEC=2, COUNTDOWN_SEC=3, rising start -> round_init pulse 1 cycle, countdown 3,2,1, then state=10 and run=1 after exactly 6 frame_ticks.
- In PLAY, 3 p1_deposit pulses and 1 p2_deposit, plus p2_hit and p2_deposit in the same cycle -> p1_score=3, p2_score=1, respawn_p2 pulses once.
- SCORE_W=2, 5 p1_deposit pulses -> p1_score saturates at 3.
- ROUND_SEC=2 with p1=2, p2=2 -> END after 2 seconds, winner=11, run=0. Then either END_HOLD_SEC ticks elapse or a start rise occurs -> state=00.
- Reset asserted mid-PLAY with nonzero scores -> next cycle state=00, scores 0, run 0, no respawn pulses.
